// File: rtl/fsm_state_cov_monitor_pkg.sv
`default_nettype none
// fsm_cov_pkg: shared types and default parameters for the FSM state-coverage monitor.
package fsm_cov_pkg;

  typedef enum logic [0:0] {
    TRK_IDLE  = 1'b0,
    TRK_TRACK = 1'b1
  } trk_state_t;

  localparam int DEF_NUM_STATES = 8;
  localparam int DEF_STATE_W    = 3;
  localparam int DEF_CNT_W      = 16;

endpackage
`default_nettype wire

// File: rtl/fsm_state_cov_monitor_if.sv
`default_nettype none
// fsm_state_cov_monitor_if: observation, read-port and status signals of the monitor.
// FSM_COV_TRANS_EN adds the trans_hit_o transition matrix.
interface fsm_state_cov_monitor_if
  import fsm_cov_pkg::*;
#(
  parameter int NUM_STATES = DEF_NUM_STATES,
  parameter int STATE_W    = DEF_STATE_W,
  parameter int CNT_W      = DEF_CNT_W
);
  localparam int IDX_W = $clog2(NUM_STATES + 1);

  logic [STATE_W-1:0]    state_i;
  logic                  sample_en_i;
  logic                  clear_i;
  logic                  rd_req_i;
  logic [IDX_W-1:0]      rd_idx_i;
  logic                  rd_valid_o;
  logic [CNT_W-1:0]      rd_data_o;
  logic [NUM_STATES-1:0] hit_mask_o;
  logic                  all_covered_o;
  logic                  illegal_o;
`ifdef FSM_COV_TRANS_EN
  logic [NUM_STATES*NUM_STATES-1:0] trans_hit_o;
`endif

  modport master (
    output state_i, sample_en_i, clear_i, rd_req_i, rd_idx_i,
    input  rd_valid_o, rd_data_o, hit_mask_o, all_covered_o, illegal_o
`ifdef FSM_COV_TRANS_EN
    , input trans_hit_o
`endif
  );

  modport slave (
    input  state_i, sample_en_i, clear_i, rd_req_i, rd_idx_i,
    output rd_valid_o, rd_data_o, hit_mask_o, all_covered_o, illegal_o
`ifdef FSM_COV_TRANS_EN
    , output trans_hit_o
`endif
  );

endinterface
`default_nettype wire

// File: rtl/fsm_state_cov_monitor_sat_counter.sv
`default_nettype none
// sat_counter: W-bit up counter that sticks at all-ones, with synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !(&q)) begin
      q <= q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fsm_state_cov_monitor.sv
`default_nettype none
// fsm_state_cov_monitor: passive per-state entry counter, illegal-encoding flag and coverage report.
// Optional macro FSM_COV_TRANS_EN adds a from/to transition hit matrix (trans_hit_o).
module fsm_state_cov_monitor
  import fsm_cov_pkg::*;
#(
  parameter int NUM_STATES = DEF_NUM_STATES,
  parameter int STATE_W    = DEF_STATE_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fsm_state_cov_monitor_if.slave bus
);

  localparam int               IDX_W    = $clog2(NUM_STATES + 1);
  localparam logic [STATE_W:0] NUM_ST_V = (STATE_W + 1)'(NUM_STATES);
  localparam logic [IDX_W-1:0] ILL_IDX  = IDX_W'(NUM_STATES);

  trk_state_t            trk_q, trk_d;
  logic [STATE_W-1:0]    prev_q, prev_d;
  logic                  count_evt;
  logic                  legal;
  logic                  clr;
  logic [NUM_STATES:0]   inc;
  logic [CNT_W-1:0]      cnt [NUM_STATES+1];
  logic [NUM_STATES-1:0] hit_q, hit_d;
  logic                  all_cov_q;
  logic                  illegal_q;
  logic                  rd_valid_q;
  logic [CNT_W-1:0]      rd_data_q;

  assign clr   = bus.clear_i;
  assign legal = {1'b0, bus.state_i} < NUM_ST_V;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk_q  <= TRK_IDLE;
      prev_q <= '0;
    end else begin
      trk_q  <= trk_d;
      prev_q <= prev_d;
    end
  end

  // Only entries count: a sample equal to the remembered state is a dwell cycle.
  always_comb begin
    trk_d     = trk_q;
    prev_d    = prev_q;
    count_evt = 1'b0;
    if (clr) begin
      trk_d = TRK_IDLE;
    end else if (bus.sample_en_i) begin
      case (trk_q)
        TRK_IDLE: begin
          count_evt = 1'b1;
          prev_d    = bus.state_i;
          trk_d     = TRK_TRACK;
        end
        TRK_TRACK: begin
          if (bus.state_i != prev_q) begin
            count_evt = 1'b1;
            prev_d    = bus.state_i;
          end
        end
        default: trk_d = TRK_IDLE;
      endcase
    end
  end

  // Slot NUM_STATES is the shared counter for every illegal encoding.
  generate
    for (genvar i = 0; i <= NUM_STATES; i++) begin : g_cnt
      if (i < NUM_STATES) begin : g_legal
        localparam logic [STATE_W-1:0] ENC = STATE_W'(i);
        assign inc[i] = count_evt && (bus.state_i == ENC);
      end else begin : g_illegal
        assign inc[i] = count_evt && !legal;
      end
      sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (inc[i]),
        .q     (cnt[i])
      );
    end
  endgenerate

  assign hit_d = hit_q | inc[NUM_STATES-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q     <= '0;
      all_cov_q <= 1'b0;
      illegal_q <= 1'b0;
    end else if (clr) begin
      hit_q     <= '0;
      all_cov_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      hit_q     <= hit_d;
      all_cov_q <= &hit_d;
      if (inc[NUM_STATES]) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Reads see the counters before this cycle's increment or clear takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_req_i;
      if (bus.rd_req_i) begin
        rd_data_q <= (bus.rd_idx_i <= ILL_IDX) ? cnt[bus.rd_idx_i] : '0;
      end
    end
  end

  assign bus.rd_valid_o    = rd_valid_q;
  assign bus.rd_data_o     = rd_data_q;
  assign bus.hit_mask_o    = hit_q;
  assign bus.all_covered_o = all_cov_q;
  assign bus.illegal_o     = illegal_q;

`ifdef FSM_COV_TRANS_EN
  logic [NUM_STATES*NUM_STATES-1:0] trans_q, trans_set;
  logic                             trans_evt;

  // The first sample out of IDLE has no predecessor, so it records nothing.
  assign trans_evt = count_evt && (trk_q == TRK_TRACK);

  generate
    for (genvar f = 0; f < NUM_STATES; f++) begin : g_from
      for (genvar t = 0; t < NUM_STATES; t++) begin : g_to
        localparam logic [STATE_W-1:0] F_ENC = STATE_W'(f);
        localparam logic [STATE_W-1:0] T_ENC = STATE_W'(t);
        assign trans_set[f*NUM_STATES+t] = trans_evt && (prev_q == F_ENC) && (bus.state_i == T_ENC);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trans_q <= '0;
    end else if (clr) begin
      trans_q <= '0;
    end else begin
      trans_q <= trans_q | trans_set;
    end
  end

  assign bus.trans_hit_o = trans_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsm_state_cov_monitor.sv
`default_nettype none
// Bench: two monitors (8 states/16-bit and 6 states/4-bit) share stimulus and are
// compared each cycle with an entry-count model, plus table and directed sequences.
module tb_fsm_state_cov_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] st;
  logic       smp, clr, rq;
  logic [3:0] idx;

  fsm_state_cov_monitor_if #(.NUM_STATES(8), .STATE_W(3), .CNT_W(16)) ifa ();
  fsm_state_cov_monitor_if #(.NUM_STATES(6), .STATE_W(3), .CNT_W(4))  ifb ();

  assign ifa.state_i     = st;
  assign ifa.sample_en_i = smp;
  assign ifa.clear_i     = clr;
  assign ifa.rd_req_i    = rq;
  assign ifa.rd_idx_i    = idx;
  assign ifb.state_i     = st;
  assign ifb.sample_en_i = smp;
  assign ifb.clear_i     = clr;
  assign ifb.rd_req_i    = rq;
  assign ifb.rd_idx_i    = idx[2:0];

  fsm_state_cov_monitor #(.NUM_STATES(8), .STATE_W(3), .CNT_W(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );
  fsm_state_cov_monitor #(.NUM_STATES(6), .STATE_W(3), .CNT_W(4)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: per instance, counts per state (slot n = illegal), last state seen.
  int        m_cnt  [2][9];
  int        m_prev [2];
  bit [7:0]  m_hit  [2];
  bit        m_ill  [2];
  bit        m_rv   [2];
  int        m_rd   [2];
  bit [63:0] m_trans[2];

  function automatic int ns(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic int maxc(input int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  function automatic bit full(input int k);
    return m_hit[k] == 8'((1 << ns(k)) - 1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear(input int k);
    for (int i = 0; i < 9; i++) m_cnt[k][i] = 0;
    m_prev[k]  = -1;
    m_hit[k]   = '0;
    m_ill[k]   = 1'b0;
    m_trans[k] = '0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      model_clear(k);
      m_rv[k] = 1'b0;
      m_rd[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int n  = ns(k);
      int s  = int'(st);
      int ix = (k == 0) ? int'(idx) : int'(idx[2:0]);
      m_rv[k] = rq;
      if (rq) m_rd[k] = (ix <= n) ? m_cnt[k][ix] : 0;
      if (clr) begin
        model_clear(k);
      end else if (smp && s != m_prev[k]) begin
        int slot = (s < n) ? s : n;
        if (m_cnt[k][slot] < maxc(k)) m_cnt[k][slot]++;
        if (s < n) begin
          m_hit[k][s] = 1'b1;
          if (m_prev[k] >= 0 && m_prev[k] < n) m_trans[k][m_prev[k]*n + s] = 1'b1;
        end else begin
          m_ill[k] = 1'b1;
        end
        m_prev[k] = s;
      end
    end
  endtask

  task automatic compare_all();
    chk("a_rd_valid", 64'(ifa.rd_valid_o), 64'(m_rv[0]));
    if (m_rv[0]) chk("a_rd_data", 64'(ifa.rd_data_o), 64'(m_rd[0]));
    chk("a_hit_mask", 64'(ifa.hit_mask_o), 64'(m_hit[0]));
    chk("a_all_covered", 64'(ifa.all_covered_o), 64'(full(0)));
    chk("a_illegal", 64'(ifa.illegal_o), 64'(m_ill[0]));
    chk("b_rd_valid", 64'(ifb.rd_valid_o), 64'(m_rv[1]));
    if (m_rv[1]) chk("b_rd_data", 64'(ifb.rd_data_o), 64'(m_rd[1]));
    chk("b_hit_mask", 64'(ifb.hit_mask_o), 64'(m_hit[1][5:0]));
    chk("b_all_covered", 64'(ifb.all_covered_o), 64'(full(1)));
    chk("b_illegal", 64'(ifb.illegal_o), 64'(m_ill[1]));
`ifdef FSM_COV_TRANS_EN
    chk("a_trans_hit", 64'(ifa.trans_hit_o), m_trans[0]);
    chk("b_trans_hit", 64'(ifb.trans_hit_o), 64'(m_trans[1][35:0]));
`endif
  endtask

  task automatic set_in(input bit s_smp, input int s_st, input bit s_clr, input bit s_rq, input int s_idx);
    smp = s_smp;
    st  = 3'(s_st);
    clr = s_clr;
    rq  = s_rq;
    idx = 4'(s_idx);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  typedef struct {
    bit smp;
    int st;
    bit rq;
    int idx;
    int hit;
    bit rv;
    int rd;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 0, 1'b0, 0, 'h01, 1'b0, 0};
    tbl[1]  = '{1'b1, 0, 1'b0, 0, 'h01, 1'b0, 0};
    tbl[2]  = '{1'b1, 1, 1'b0, 0, 'h03, 1'b0, 0};
    tbl[3]  = '{1'b1, 1, 1'b0, 0, 'h03, 1'b0, 0};
    tbl[4]  = '{1'b1, 2, 1'b0, 0, 'h07, 1'b0, 0};
    tbl[5]  = '{1'b1, 0, 1'b0, 0, 'h07, 1'b0, 0};
    tbl[6]  = '{1'b0, 0, 1'b1, 0, 'h07, 1'b1, 2};
    tbl[7]  = '{1'b0, 0, 1'b1, 1, 'h07, 1'b1, 1};
    tbl[8]  = '{1'b0, 0, 1'b1, 2, 'h07, 1'b1, 1};
    tbl[9]  = '{1'b0, 0, 1'b1, 3, 'h07, 1'b1, 0};
    tbl[10] = '{1'b0, 0, 1'b1, 8, 'h07, 1'b1, 0};
    tbl[11] = '{1'b0, 0, 1'b1, 9, 'h07, 1'b1, 0};
    tbl[12] = '{1'b0, 0, 1'b0, 0, 'h07, 1'b0, 0};

    set_in(1'b0, 0, 1'b0, 1'b0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    chk("a_rd_data_reset", 64'(ifa.rd_data_o), 64'd0);
    chk("b_rd_data_reset", 64'(ifb.rd_data_o), 64'd0);
    rst_n = 1'b1;

    // Entry counting: 0,0,1,1,2,0 then read back
    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i].smp, tbl[i].st, 1'b0, tbl[i].rq, tbl[i].idx);
      step();
      chk($sformatf("tbl%0d_hit", i), 64'(ifa.hit_mask_o), 64'(tbl[i].hit));
      chk($sformatf("tbl%0d_all_cov", i), 64'(ifa.all_covered_o), 64'd0);
      chk($sformatf("tbl%0d_rv", i), 64'(ifa.rd_valid_o), 64'(tbl[i].rv));
      if (tbl[i].rv) chk($sformatf("tbl%0d_rd", i), 64'(ifa.rd_data_o), 64'(tbl[i].rd));
    end

    // Full coverage: visit 0..7 once each
    set_in(1'b0, 0, 1'b1, 1'b0, 0);
    step();
    for (int s = 0; s < 8; s++) begin
      set_in(1'b1, s, 1'b0, 1'b0, 0);
      step();
      chk($sformatf("cov_all_a_s%0d", s), 64'(ifa.all_covered_o), 64'(s == 7));
    end
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 0, 1'b0, 1'b1, i);
      step();
      chk($sformatf("cov_rd_a_%0d", i), 64'(ifa.rd_data_o), 64'd1);
    end

    // Saturation: alternate 3,4 for 40 samples
    set_in(1'b0, 0, 1'b1, 1'b0, 0);
    step();
    for (int j = 0; j < 40; j++) begin
      set_in(1'b1, (j % 2 == 0) ? 3 : 4, 1'b0, 1'b0, 0);
      step();
    end
    for (int i = 3; i <= 4; i++) begin
      set_in(1'b0, 0, 1'b0, 1'b1, i);
      step();
      chk($sformatf("sat_b_cnt%0d", i), 64'(ifb.rd_data_o), 64'd15);
      chk($sformatf("sat_a_cnt%0d", i), 64'(ifa.rd_data_o), 64'd20);
    end

    // Illegal encodings on the 6-state instance: 5,6,6,7
    set_in(1'b0, 0, 1'b1, 1'b0, 0);
    step();
    for (int j = 0; j < 4; j++) begin
      set_in(1'b1, (j == 0) ? 5 : (j == 3) ? 7 : 6, 1'b0, 1'b0, 0);
      step();
    end
    chk("ill_b_flag", 64'(ifb.illegal_o), 64'd1);
    chk("ill_a_flag", 64'(ifa.illegal_o), 64'd0);
    set_in(1'b0, 0, 1'b0, 1'b1, 5);
    step();
    chk("ill_b_cnt5", 64'(ifb.rd_data_o), 64'd1);

    // Clear with sample and read: read returns pre-clear value, sample dropped
    set_in(1'b1, 2, 1'b1, 1'b1, 6);
    step();
    chk("clr_b_rd_ill_preclear", 64'(ifb.rd_data_o), 64'd2);
    chk("clr_b_illegal_cleared", 64'(ifb.illegal_o), 64'd0);
    set_in(1'b1, 2, 1'b0, 1'b0, 0);
    step();
    set_in(1'b0, 0, 1'b0, 1'b1, 2);
    step();
    chk("clr_a_cnt2", 64'(ifa.rd_data_o), 64'd1);
    chk("clr_b_cnt2", 64'(ifb.rd_data_o), 64'd1);

    // Back-to-back reads with reset during the third request
    set_in(1'b0, 0, 1'b0, 1'b1, 0);
    step();
    set_in(1'b0, 0, 1'b0, 1'b1, 1);
    step();
    set_in(1'b0, 0, 1'b0, 1'b1, 2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rstmid_a_rv", 64'(ifa.rd_valid_o), 64'd0);
    chk("rstmid_b_rv", 64'(ifb.rd_valid_o), 64'd0);
    compare_all();
    set_in(1'b0, 0, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      set_in(1'b0, 0, 1'b0, 1'b1, i);
      step();
      chk($sformatf("post_rst_a_rd%0d", i), 64'(ifa.rd_data_o), 64'd0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      int s_st;
      s_st = ($urandom_range(0, 2) == 0) ? int'(st) : int'($urandom_range(0, 7));
      set_in($urandom_range(0, 9) < 7, s_st, $urandom_range(0, 59) == 0,
             $urandom_range(0, 1) == 1, int'($urandom_range(0, 15)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fsm_state_cov_monitor.md
Name: fsm_state_cov_monitor

Overview:
- Synthesizable, parametrised state-coverage monitor for any FSM in the design, e.g. the T-bird tail light controller.
- Counts entries into each of NUM_STATES encoded states using saturating counters, flags illegal encodings, and reports full coverage.
- Exposes a registered read port so a bench or debug bus can dump the per-state counts at end of test.
- Sits beside the FSM under observation, passive on its state bus.

Parameters:
- NUM_STATES, 8, number of legal state encodings (0..NUM_STATES-1); range 2..256.
- STATE_W, 3, width of observed state bus; must satisfy 2**STATE_W >= NUM_STATES.
- CNT_W, 16, width of each per-state counter and of the illegal counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- state_i  in  STATE_W  observed FSM state.
- sample_en_i  in  1  sample state_i this cycle when high.
- clear_i  in  1  synchronous clear of all counters and flags.
- rd_req_i  in  1  read request, one-cycle pulse.
- rd_idx_i  in  $clog2(NUM_STATES+1)  counter index; NUM_STATES selects the illegal counter.
- rd_valid_o  out  1  read data valid.
- rd_data_o  out  CNT_W  read data.
- hit_mask_o  out  NUM_STATES  bit i set once state i has been counted.
- all_covered_o  out  1  AND of hit_mask_o.
- illegal_o  out  1  sticky flag: an illegal encoding was sampled.

Behaviour:
- Reset (async, rst_n low): all counters 0, hit_mask_o 0, all_covered_o 0, illegal_o 0, rd_valid_o 0, rd_data_o 0, tracker FSM in IDLE.
- Tracker FSM, two states:
  - IDLE (no reference state yet). On sample_en_i, count state_i, store it as prev, go to TRACK.
  - TRACK. On sample_en_i with state_i != prev: count state_i and update prev. On sample_en_i with state_i == prev: no count.
  - Net effect: entries are counted, not dwell cycles. The first sample after reset or clear always counts.
- Counting:
  - Legal state (state_i < NUM_STATES): cnt[state_i] += 1, saturating at 2**CNT_W-1. Also sets hit_mask_o[state_i].
  - Illegal state (state_i >= NUM_STATES): illegal counter += 1 (saturating) and illegal_o set. prev is still updated, so a repeated illegal value is counted once.
- Outputs hit_mask_o, all_covered_o and illegal_o update the cycle after the sample, since they are registered.
- clear_i: synchronous. All counters, hit_mask_o, illegal_o and all_covered_o go to 0; tracker returns to IDLE. Clear has priority over a simultaneous sample, so that sample is dropped.
- Read port:
  - rd_req_i at cycle N gives rd_valid_o=1 with rd_data_o at cycle N+1, for one cycle.
  - rd_data_o reflects the counter value at the end of cycle N, i.e. excluding any increment from a sample in cycle N.
  - rd_idx_i > NUM_STATES returns 0 with rd_valid_o still asserted.
  - rd_req_i in back-to-back cycles is legal; one response per cycle.
  - rd_req_i together with clear_i returns the pre-clear value.
- Reset asserted mid-read: rd_valid_o drops immediately.

Optional Feature:
- Macro FSM_COV_TRANS_EN.
- When defined:
  - Adds output trans_hit_o, NUM_STATES*NUM_STATES bits. Bit (from*NUM_STATES+to) sets on any counted legal-to-legal change from prev to state_i; transitions involving an illegal state are not recorded.
  - trans_hit_o is cleared by reset and by clear_i.
  - The first sample from IDLE records no transition.
- When undefined: the port and its logic are absent; everything else is identical.

Decomposition:
- Package fsm_cov_pkg: tracker enum trk_state_t {TRK_IDLE, TRK_TRACK}; constants DEF_NUM_STATES=8, DEF_STATE_W=3, DEF_CNT_W=16.
- Sub-module sat_counter: parameter W; inputs clk, rst_n, clr, inc; output q.
  - Saturating increment with synchronous clear.
  - Instantiated NUM_STATES+1 times via generate.

Test Plan:
- Reset, then sample 0,0,1,1,2,0 with sample_en_i high every cycle, NUM_STATES=8 → cnt[0]=2, cnt[1]=1, cnt[2]=1; hit_mask_o=8'b0000_0111; all_covered_o=0.
- Visit states 0..7 once each → all_covered_o=1 one cycle after the sample of 7; each counter reads 1.
- CNT_W=4, alternate states 3,4 for 40 samples → cnt[3] and cnt[4] read 15 (saturated).
- NUM_STATES=6, STATE_W=3, sample 5,6,6,7 → illegal_o=1; rd_idx_i=6 reads 2; cnt[5] reads 1.
- Sample 2 while clear_i is high, then sample 2 → cnt[2] reads 1, since the first sample was dropped and IDLE restarts counting.
- Read each index back-to-back, with rst_n pulsed low during the third request → rd_valid_o=0 immediately; all subsequent reads return 0.
